pipe_seq_ctrl: RTL and testbench
================================

// Module: pipe_seq_ctrl
// PURPOSE
//   Central sequencer for the 5-stage pipeline registers (F/D, D/E, E/M, M/W).
//   - Detects Tuse/Tnew data hazards and mult/div unit-busy hazards.
//   - Emits per-register write-enable, bubble and exception-redirect controls.
//   - Owns the mult/div busy countdown and a saturating stall-cycle counter.
//   - Sits beside the datapath; every pipeline register takes its WE/flush/req from here.
// PARAMETERS
//   MULT_LAT  5   busy cycles for mult/multu after issue from E
//   DIV_LAT   10  busy cycles for div/divu after issue from E
//   CNT_W     32  width of stall_cycles counter
// PORTS
//   clk          in   1   clock
//   reset        in   1   synchronous, active-high
//   d_rs         in   5   rs index of instruction in D
//   d_rt         in   5   rt index of instruction in D
//   d_tuse_rs    in   2   cycles until D instr needs rs (3 = unused)
//   d_tuse_rt    in   2   cycles until D instr needs rt (3 = unused)
//   d_is_md      in   1   D instr uses HI/LO or mult/div unit
//   d_is_eret    in   1   D instr is eret
//   e_a3         in   5   dest reg of instr in E (0 = none)
//   e_tnew       in   2   cycles until E result is forwardable
//   e_mtc0_epc   in   1   E instr is mtc0 writing EPC
//   e_md_start   in   1   E instr is mult/multu/div/divu (issues this cycle)
//   e_md_div     in   1   qualifies e_md_start: 1 = div family
//   m_a3         in   5   dest reg of instr in M
//   m_tnew       in   2   cycles until M result is forwardable
//   m_mtc0_epc   in   1   M instr is mtc0 writing EPC
//   m_exc_req    in   1   CP0 takes exception/interrupt this cycle
//   pc_en        out  1   PC register write enable
//   fd_we        out  1   F/D register write enable
//   de_flush     out  1   D/E inserts bubble (PC/isBD still pass through)
//   de_we        out  1   D/E register write enable
//   req          out  1   exception redirect to all pipeline regs and PC
//   md_start_ok  out  1   e_md_start gated by !req; drives mult/div unit start
//   md_busy      out  1   mult/div countdown nonzero
//   stall_cycles out  CNT_W  count of cycles with stall asserted (saturating)
// BEHAVIOUR
//   - Reset: md_cnt=0, md_busy=0, stall_cycles=0. Combinational outputs evaluate as
//     with no hazard: pc_en=fd_we=de_we=1, de_flush=0, req=0.
//   - Data stall (combinational):
//       stall_rs = d_tuse_rs != 3 && d_rs != 0 &&
//                  ((d_rs == e_a3 && d_tuse_rs < e_tnew) || (d_rs == m_a3 && d_tuse_rs < m_tnew))
//       stall_rt = same rule with d_rt and d_tuse_rt.
//   - MD stall: d_is_md && (md_busy || e_md_start).
//   - ERET stall: d_is_eret && (e_mtc0_epc || m_mtc0_epc).
//   - stall = stall_rs | stall_rt | md_stall | eret_stall.
//   - Output priority: req > stall > run.
//       req=m_exc_req; when req=1 force de_flush=0, pc_en=fd_we=de_we=1
//         (target regs load handler PC 0x4180).
//       stall (and no req): pc_en=0, fd_we=0, de_flush=1, de_we=1.
//       run: pc_en=fd_we=de_we=1, de_flush=0.
//   - MD counter (registered):
//       md_start_ok = e_md_start & ~m_exc_req.
//       md_start_ok: load md_cnt = e_md_div ? DIV_LAT : MULT_LAT.
//       else if md_cnt != 0: decrement by 1.
//       md_busy = (md_cnt != 0); first busy cycle is the cycle after issue.
//       Exception does NOT clear a running count: the issuing instr has already committed.
//       A start coincident with m_exc_req is squashed (no load).
//   - stall_cycles increments on each cycle with stall & ~req; holds at all-ones.
//   - Reset mid-operation: md_cnt, md_busy and stall_cycles clear on that edge;
//     a pending start is discarded.
// TESTING
//   - RAW vs load: e_a3=5, e_tnew=2, d_rs=5, d_tuse_rs=1 -> pc_en=0, de_flush=1 for
//     that cycle; e_tnew=1 next -> run.
//   - $0 / unused: d_rs=0 or d_tuse_rs=3 with e_a3=0 match -> no stall.
//   - Divide busy: e_md_start=1, e_md_div=1 at T0 -> md_busy=1 T1..T10, 0 at T11;
//     d_is_md during T1..T10 stalls; stall_cycles grows by stall count.
//   - Squash: e_md_start=1 with m_exc_req=1 -> md_start_ok=0, md_cnt stays 0, req=1,
//     de_flush=0.
//   - Exception over stall: stall conditions true and m_exc_req=1 -> req=1, pc_en=1,
//     fd_we=1, stall_cycles unchanged.
//   - Reset during mult countdown (md_cnt=3) -> next cycle md_busy=0, stall_cycles=0.

Source files
------------

// File: rtl/pipe_seq_ctrl.sv
// Pipeline sequencer: Tuse/Tnew and mult/div hazard detection, per-register
// write-enable/bubble/redirect controls, mult/div busy countdown and stall counter.
module pipe_seq_ctrl #(
    parameter int unsigned MULT_LAT = 5,
    parameter int unsigned DIV_LAT  = 10,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       d_rs,
    input  logic [4:0]       d_rt,
    input  logic [1:0]       d_tuse_rs,
    input  logic [1:0]       d_tuse_rt,
    input  logic             d_is_md,
    input  logic             d_is_eret,
    input  logic [4:0]       e_a3,
    input  logic [1:0]       e_tnew,
    input  logic             e_mtc0_epc,
    input  logic             e_md_start,
    input  logic             e_md_div,
    input  logic [4:0]       m_a3,
    input  logic [1:0]       m_tnew,
    input  logic             m_mtc0_epc,
    input  logic             m_exc_req,
    output logic             pc_en,
    output logic             fd_we,
    output logic             de_flush,
    output logic             de_we,
    output logic             req,
    output logic             md_start_ok,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int unsigned MAX_LAT = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
    localparam int unsigned MD_W    = $clog2(MAX_LAT + 1);

    logic [MD_W-1:0] md_cnt;
    logic            stall_rs;
    logic            stall_rt;
    logic            md_stall;
    logic            eret_stall;
    logic            stall;

    // A source stalls when a younger-stage producer will not have its result
    // forwardable by the time D needs it; $0 and unused operands never stall.
    function automatic logic src_hazard(
        input logic [4:0] src,
        input logic [1:0] tuse,
        input logic [4:0] ea3,
        input logic [1:0] etnew,
        input logic [4:0] ma3,
        input logic [1:0] mtnew
    );
        return (tuse != 2'd3) && (src != 5'd0) &&
               (((src == ea3) && (tuse < etnew)) || ((src == ma3) && (tuse < mtnew)));
    endfunction

    always_comb begin
        stall_rs   = src_hazard(d_rs, d_tuse_rs, e_a3, e_tnew, m_a3, m_tnew);
        stall_rt   = src_hazard(d_rt, d_tuse_rt, e_a3, e_tnew, m_a3, m_tnew);
        md_stall   = d_is_md && (md_busy || e_md_start);
        eret_stall = d_is_eret && (e_mtc0_epc || m_mtc0_epc);
        stall      = stall_rs | stall_rt | md_stall | eret_stall;
    end

    always_comb begin
        pc_en       = 1'b1;
        fd_we       = 1'b1;
        de_flush    = 1'b0;
        de_we       = 1'b1;
        req         = m_exc_req;
        md_start_ok = e_md_start & ~m_exc_req;
        if (!m_exc_req && stall) begin
            pc_en    = 1'b0;
            fd_we    = 1'b0;
            de_flush = 1'b1;
        end
    end

    assign md_busy = (md_cnt != '0);

    // An exception does not cancel a running count: the issuing instruction
    // has already committed; only a start coincident with the exception is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            md_cnt <= '0;
        end else if (md_start_ok) begin
            md_cnt <= e_md_div ? MD_W'(DIV_LAT) : MD_W'(MULT_LAT);
        end else if (md_cnt != '0) begin
            md_cnt <= md_cnt - MD_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (stall && !m_exc_req && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_seq_ctrl.sv
// Self-checking bench for pipe_seq_ctrl: vector table plus hand-written
// mult/div and exception sequences, checked through an expected-result queue.
module tb_pipe_seq_ctrl;

    localparam logic [5:0] RUN = 6'b110100;
    localparam logic [5:0] STL = 6'b001100;
    localparam logic [5:0] REQ = 6'b110110;
    localparam logic [5:0] OK  = 6'b000001;

    logic        clk;
    logic        reset;
    logic [4:0]  d_rs, d_rt, e_a3, m_a3;
    logic [1:0]  d_tuse_rs, d_tuse_rt, e_tnew, m_tnew;
    logic        d_is_md, d_is_eret, e_mtc0_epc, e_md_start, e_md_div, m_mtc0_epc, m_exc_req;
    logic        pc_en, fd_we, de_flush, de_we, req, md_start_ok, md_busy;
    logic [31:0] stall_cycles;
    logic        s_pc_en, s_fd_we, s_de_flush, s_de_we, s_req, s_md_start_ok, s_md_busy;
    logic [1:0]  s_stall_cycles;

    pipe_seq_ctrl dut (
        .clk(clk), .reset(reset), .d_rs(d_rs), .d_rt(d_rt),
        .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt), .d_is_md(d_is_md), .d_is_eret(d_is_eret),
        .e_a3(e_a3), .e_tnew(e_tnew), .e_mtc0_epc(e_mtc0_epc), .e_md_start(e_md_start),
        .e_md_div(e_md_div), .m_a3(m_a3), .m_tnew(m_tnew), .m_mtc0_epc(m_mtc0_epc),
        .m_exc_req(m_exc_req), .pc_en(pc_en), .fd_we(fd_we), .de_flush(de_flush),
        .de_we(de_we), .req(req), .md_start_ok(md_start_ok), .md_busy(md_busy),
        .stall_cycles(stall_cycles)
    );

    // Narrow counter instance exercises the saturation boundary.
    pipe_seq_ctrl #(.MULT_LAT(5), .DIV_LAT(10), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .d_rs(d_rs), .d_rt(d_rt),
        .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt), .d_is_md(d_is_md), .d_is_eret(d_is_eret),
        .e_a3(e_a3), .e_tnew(e_tnew), .e_mtc0_epc(e_mtc0_epc), .e_md_start(e_md_start),
        .e_md_div(e_md_div), .m_a3(m_a3), .m_tnew(m_tnew), .m_mtc0_epc(m_mtc0_epc),
        .m_exc_req(m_exc_req), .pc_en(s_pc_en), .fd_we(s_fd_we), .de_flush(s_de_flush),
        .de_we(s_de_we), .req(s_req), .md_start_ok(s_md_start_ok), .md_busy(s_md_busy),
        .stall_cycles(s_stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [4:0] rs, rt;
        logic [1:0] trs, trt;
        logic       md, eret;
        logic [4:0] ea3;
        logic [1:0] etnew;
        logic       emtc0, estart, ediv;
        logic [4:0] ma3;
        logic [1:0] mtnew;
        logic       mmtc0, exc;
        logic [5:0] exp;
    } vec_t;

    typedef struct {
        string       name;
        logic [5:0]  ctl;
        logic        busy;
        logic [31:0] sc;
        logic [1:0]  sc_sat;
    } exp_t;

    vec_t        tbl[$];
    exp_t        exp_q[$];
    int unsigned n_pass  = 0;
    int unsigned n_total = 0;
    int unsigned m_cnt   = 0;
    logic [31:0] m_sc    = '0;

    function automatic vec_t mk(
        input logic rst, input logic [4:0] rs, input logic [4:0] rt,
        input logic [1:0] trs, input logic [1:0] trt, input logic md, input logic eret,
        input logic [4:0] ea3, input logic [1:0] etnew, input logic emtc0,
        input logic estart, input logic ediv, input logic [4:0] ma3,
        input logic [1:0] mtnew, input logic mmtc0, input logic exc, input logic [5:0] exp
    );
        vec_t v;
        v.rst = rst; v.rs = rs; v.rt = rt; v.trs = trs; v.trt = trt; v.md = md;
        v.eret = eret; v.ea3 = ea3; v.etnew = etnew; v.emtc0 = emtc0; v.estart = estart;
        v.ediv = ediv; v.ma3 = ma3; v.mtnew = mtnew; v.mmtc0 = mmtc0; v.exc = exc;
        v.exp = exp;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_total++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, want);
    endtask

    task automatic drive(input vec_t v);
        reset = v.rst; d_rs = v.rs; d_rt = v.rt; d_tuse_rs = v.trs; d_tuse_rt = v.trt;
        d_is_md = v.md; d_is_eret = v.eret; e_a3 = v.ea3; e_tnew = v.etnew;
        e_mtc0_epc = v.emtc0; e_md_start = v.estart; e_md_div = v.ediv;
        m_a3 = v.ma3; m_tnew = v.mtnew; m_mtc0_epc = v.mmtc0; m_exc_req = v.exc;
    endtask

    // Drive after a rising edge, compare at the falling edge, then advance the
    // reference state to what the next rising edge should produce.
    task automatic apply(input string nm, input vec_t v);
        exp_t e, got;
        @(posedge clk);
        #1;
        drive(v);
        e.name   = nm;
        e.ctl    = v.exp;
        e.busy   = (m_cnt != 0);
        e.sc     = m_sc;
        e.sc_sat = (m_sc > 32'd3) ? 2'd3 : m_sc[1:0];
        exp_q.push_back(e);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            check({nm, "_queue"}, 32'd0, 32'd1);
        end else begin
            got = exp_q.pop_front();
            check({got.name, "_ctl"}, {26'd0, pc_en, fd_we, de_flush, de_we, req, md_start_ok},
                  {26'd0, got.ctl});
            check({got.name, "_busy"}, {31'd0, md_busy}, {31'd0, got.busy});
            check({got.name, "_stall_cycles"}, stall_cycles, got.sc);
            check({got.name, "_sat"}, {30'd0, s_stall_cycles}, {30'd0, got.sc_sat});
        end
        if (v.rst) begin
            m_cnt = 0;
            m_sc  = '0;
        end else begin
            if (v.exp[0]) m_cnt = v.ediv ? 10 : 5;
            else if (m_cnt != 0) m_cnt--;
            if (v.exp[3] && !v.exp[1] && m_sc != '1) m_sc++;
        end
    endtask

    initial begin
        logic [31:0] sc0;
        drive(mk(1, 0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RUN));
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        tbl.push_back(mk(0, 0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RUN));      // reset state
        tbl.push_back(mk(0, 5, 0, 1, 3, 0, 0, 5, 2, 0, 0, 0, 0, 0, 0, 0, STL));      // RAW vs load
        tbl.push_back(mk(0, 5, 0, 1, 3, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0, RUN));      // tnew caught up
        tbl.push_back(mk(0, 5, 0, 1, 3, 0, 0, 6, 2, 0, 0, 0, 0, 0, 0, 0, RUN));      // different reg
        tbl.push_back(mk(0, 0, 0, 0, 3, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, RUN));      // $0 source
        tbl.push_back(mk(0, 5, 0, 3, 3, 0, 0, 5, 2, 0, 0, 0, 0, 0, 0, 0, RUN));      // rs unused
        tbl.push_back(mk(0, 0, 7, 3, 0, 0, 0, 0, 0, 0, 0, 0, 7, 1, 0, 0, STL));      // rt vs M
        tbl.push_back(mk(0, 0, 7, 3, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0, 0, 0, RUN));      // M ready
        tbl.push_back(mk(0, 0, 0, 3, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, STL));      // eret vs M mtc0
        tbl.push_back(mk(0, 0, 0, 3, 3, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, STL));      // eret vs E mtc0
        tbl.push_back(mk(0, 0, 0, 3, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, RUN));      // eret free
        tbl.push_back(mk(0, 0, 0, 3, 3, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, STL | OK)); // md behind mult issue
        tbl.push_back(mk(0, 0, 0, 3, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, STL));      // md while busy
        tbl.push_back(mk(0, 0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RUN));
        tbl.push_back(mk(1, 0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RUN));      // reset at md_cnt=3
        tbl.push_back(mk(0, 0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RUN));      // cleared
        tbl.push_back(mk(0, 0, 0, 3, 3, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, REQ));      // squashed start
        tbl.push_back(mk(0, 5, 0, 1, 3, 0, 0, 5, 2, 0, 0, 0, 0, 0, 0, 1, REQ));      // exc over stall
        tbl.push_back(mk(0, 0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RUN));      // no load seen
        tbl.push_back(mk(0, 0, 0, 3, 3, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, RUN | OK)); // mult issue
        tbl.push_back(mk(0, 0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, REQ));      // exc keeps count
        for (int unsigned i = 0; i < 5; i++)
            tbl.push_back(mk(0, 0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RUN));

        for (int unsigned i = 0; i < tbl.size(); i++)
            apply($sformatf("vec%0d", i), tbl[i]);

        // Divide: busy T1..T10, idle at T11; d_is_md stalls exactly while busy.
        apply("div_issue", mk(0, 0, 0, 3, 3, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, RUN | OK));
        sc0 = m_sc;
        for (int unsigned t = 1; t <= 11; t++)
            apply($sformatf("div_T%0d", t),
                  mk(0, 0, 0, 3, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, (t <= 10) ? STL : RUN));
        @(negedge clk);
        check("div_stall_growth", stall_cycles, sc0 + 32'd10);

        // Reset mid-mult countdown after some stalls have been counted.
        apply("mult_issue", mk(0, 0, 0, 3, 3, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, RUN | OK));
        apply("mult_c1", mk(0, 5, 0, 1, 3, 0, 0, 5, 2, 0, 0, 0, 0, 0, 0, 0, STL));
        apply("mult_c2", mk(0, 0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RUN));
        apply("mid_reset", mk(1, 0, 0, 3, 3, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, RUN | OK));
        apply("after_reset", mk(0, 0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RUN));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
